// File: rtl/polar_ctrl_pkg.sv
// Shared types and width helpers for the SC decoder control path.
package polar_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/idx_to_onehot.sv
// Index to one-hot decoder; an index >= N decodes to all zeros.
module idx_to_onehot #(
  parameter int unsigned N     = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [N-1:0]     onehot_o
);

  // Full-width compare per bit, so out-of-range codes never alias onto a valid bit.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = (idx_i == IDX_W'(i));
    end
  end

endmodule

// File: rtl/info_mask_builder.sv
// Collects K distinct bit positions over valid/ready and presents the N-bit
// information-set mask over a valid/ack handshake.
module info_mask_builder
  import polar_ctrl_pkg::*;
#(
  parameter  int unsigned N     = 10,
  localparam int unsigned IDX_W = idx_w(N),
  localparam int unsigned CNT_W = cnt_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] k_cfg_i,
  input  logic             idx_valid_i,
  output logic             idx_ready_o,
  input  logic [IDX_W-1:0] idx_data_i,
  output logic [N-1:0]     mask_out_o,
  output logic             mask_valid_o,
  input  logic             mask_ack_i,
  output logic             busy_o,
  output logic             err_dup_o,
  output logic             err_range_o
);

  state_e           state_q, state_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             err_dup_q, err_dup_d;
  logic             err_range_q, err_range_d;

  logic [N-1:0]     onehot;
  logic             in_range;
  logic             dup;
  logic             xfer;
  logic             accept;
  logic [CNT_W-1:0] k_clamped;
  logic [CNT_W-1:0] cnt_inc;

  idx_to_onehot #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_idx_to_onehot (
    .idx_i    (idx_data_i),
    .onehot_o (onehot)
  );

  assign in_range  = |onehot;
  assign dup       = |(onehot & mask_q);
  assign xfer      = idx_valid_i && (state_q == StCollect);
  assign accept    = xfer && in_range && !dup;
  assign k_clamped = (k_cfg_i > CNT_W'(N)) ? CNT_W'(N) : k_cfg_i;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      err_dup_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      err_dup_q   <= err_dup_d;
      err_range_q <= err_range_d;
    end
  end

  // start wins over any transfer or ack in the same cycle, from every state.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = (k_clamped == '0) ? StDone : StCollect;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StCollect: if (accept && (cnt_inc == k_q)) state_d = StDone;
        StDone:    if (mask_ack_i) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    err_dup_d   = err_dup_q;
    err_range_d = err_range_q;
    if (start_i) begin
      mask_d      = '0;
      cnt_d       = '0;
      k_d         = k_clamped;
      err_dup_d   = 1'b0;
      err_range_d = 1'b0;
    end else if (xfer) begin
      if (!in_range) begin
        err_range_d = 1'b1;
      end else if (dup) begin
        err_dup_d = 1'b1;
      end else begin
        mask_d = mask_q | onehot;
        cnt_d  = cnt_inc;
      end
    end
  end

  always_comb begin
    idx_ready_o  = (state_q == StCollect);
    busy_o       = (state_q == StCollect);
    mask_valid_o = (state_q == StDone);
    mask_out_o   = mask_q;
    err_dup_o    = err_dup_q;
    err_range_o  = err_range_q;
  end

endmodule

// File: tb/tb_info_mask_builder.sv
// Bench for info_mask_builder: directed vector table, hand sequences and random traffic
// checked against a behavioural model.
module tb_info_mask_builder;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [3:0] k_cfg_i;
  logic       idx_valid_i;
  logic       idx_ready_o;
  logic [3:0] idx_data_i;
  logic [9:0] mask_out_o;
  logic       mask_valid_o;
  logic       mask_ack_i;
  logic       busy_o;
  logic       err_dup_o;
  logic       err_range_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [9:0] m_mask;
  int         m_cnt;
  int         m_k;
  bit         m_collecting;
  bit         m_complete;
  bit         m_dup;
  bit         m_rng;

  typedef struct {
    logic       s;
    logic [3:0] k;
    logic       v;
    logic [3:0] d;
    logic       a;
    logic [9:0] mask;
    logic       valid;
    logic       ready;
    logic       dup;
    logic       rng;
  } vec_t;

  vec_t vecs[$];

  info_mask_builder #(
    .N (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .k_cfg_i      (k_cfg_i),
    .idx_valid_i  (idx_valid_i),
    .idx_ready_o  (idx_ready_o),
    .idx_data_i   (idx_data_i),
    .mask_out_o   (mask_out_o),
    .mask_valid_o (mask_valid_o),
    .mask_ack_i   (mask_ack_i),
    .busy_o       (busy_o),
    .err_dup_o    (err_dup_o),
    .err_range_o  (err_range_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_cnt = 0; m_k = 0;
    m_collecting = 0; m_complete = 0; m_dup = 0; m_rng = 0;
  endtask

  // One clock edge of the intended behaviour, from the inputs seen at that edge.
  task automatic model_edge(input logic s, input logic [3:0] k, input logic v,
                            input logic [3:0] d, input logic a);
    if (s) begin
      m_mask = '0; m_cnt = 0; m_dup = 0; m_rng = 0;
      m_k = (int'(k) > N) ? N : int'(k);
      m_collecting = (m_k != 0);
      m_complete   = (m_k == 0);
    end else if (m_collecting && v) begin
      if (int'(d) >= N) m_rng = 1;
      else if (m_mask[d]) m_dup = 1;
      else begin
        m_mask[d] = 1'b1;
        m_cnt++;
        if (m_cnt == m_k) begin
          m_collecting = 0;
          m_complete   = 1;
        end
      end
    end else if (m_complete && a) begin
      m_complete = 0;
    end
  endtask

  task automatic check_model();
    check("mask", 32'(mask_out_o), 32'(m_mask));
    check("mask_valid", 32'(mask_valid_o), 32'(m_complete));
    check("idx_ready", 32'(idx_ready_o), 32'(m_collecting));
    check("busy", 32'(busy_o), 32'(m_collecting));
    check("err_dup", 32'(err_dup_o), 32'(m_dup));
    check("err_range", 32'(err_range_o), 32'(m_rng));
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks after the next edge.
  task automatic step(input logic s, input logic [3:0] k, input logic v,
                      input logic [3:0] d, input logic a);
    start_i = s; k_cfg_i = k; idx_valid_i = v; idx_data_i = d; mask_ack_i = a;
    @(posedge clk);
    model_edge(s, k, v, d, a);
    #1;
    start_i = 1'b0; idx_valid_i = 1'b0; mask_ack_i = 1'b0;
    check_model();
  endtask

  function automatic vec_t mk(input logic s, input logic [3:0] k, input logic v,
                              input logic [3:0] d, input logic a, input logic [9:0] mask,
                              input logic valid, input logic ready, input logic dup,
                              input logic rng);
    vec_t r;
    r.s = s; r.k = k; r.v = v; r.d = d; r.a = a;
    r.mask = mask; r.valid = valid; r.ready = ready; r.dup = dup; r.rng = rng;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; start_i = 1'b0; k_cfg_i = '0; idx_valid_i = 1'b0;
    idx_data_i = '0; mask_ack_i = 1'b0;
    model_reset();
    #1;
    check("rst_mask", 32'(mask_out_o), 32'h0);
    check("rst_valid", 32'(mask_valid_o), 32'h0);
    check("rst_ready", 32'(idx_ready_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_errs", {30'h0, err_dup_o, err_range_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //          s  k   v  d   a  mask    vld rdy dup rng
    vecs.push_back(mk(1, 3, 0, 0, 0, 10'h000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 7, 0, 10'h080, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 10'h084, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 9, 0, 10'h284, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 10'h284, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 10'h284, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 0, 10'h000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4, 0, 10'h010, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4, 0, 10'h010, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 12, 0, 10'h010, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 10'h012, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 10'h013, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 10'h013, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 10'h000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 0, 10'h000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 10'h000, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].k, vecs[i].v, vecs[i].d, vecs[i].a);
      check($sformatf("vec%0d_mask", i), 32'(mask_out_o), 32'(vecs[i].mask));
      check($sformatf("vec%0d_valid", i), 32'(mask_valid_o), 32'(vecs[i].valid));
      check($sformatf("vec%0d_ready", i), 32'(idx_ready_o), 32'(vecs[i].ready));
      check($sformatf("vec%0d_errs", i), {30'h0, err_dup_o, err_range_o},
            {30'h0, vecs[i].dup, vecs[i].rng});
    end

    // k above N clamps to N
    step(1, 15, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 1, 4'(i), 0);
    check("clamp_mask", 32'(mask_out_o), 32'h3FF);
    check("clamp_valid", 32'(mask_valid_o), 32'h1);
    step(0, 0, 0, 0, 1);

    // Restart mid-collect, with a simultaneous offered index that must be ignored
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 6, 0);
    step(1, 1, 1, 3, 0);
    check("restart_clear", 32'(mask_out_o), 32'h0);
    step(0, 0, 1, 5, 0);
    check("restart_mask", 32'(mask_out_o), 32'h020);
    check("restart_valid", 32'(mask_valid_o), 32'h1);

    // mask_valid holds without ack
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 7, 0);
      check("hold_valid", 32'(mask_valid_o), 32'h1);
    end
    step(0, 0, 0, 0, 1);
    check("ack_valid", 32'(mask_valid_o), 32'h0);
    check("ack_mask", 32'(mask_out_o), 32'h020);

    // Asynchronous reset mid-collect
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mask", 32'(mask_out_o), 32'h0);
    check("arst_ready", 32'(idx_ready_o), 32'h0);
    check("arst_busy", 32'(busy_o), 32'h0);
    check("arst_valid", 32'(mask_valid_o), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_model();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic       s;
      logic [3:0] k;
      logic [3:0] d;
      s = ($urandom_range(0, 15) == 0) || (!m_collecting && !m_complete && $urandom_range(0, 1) == 1);
      k = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      step(s, k, 1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
